// File: rtl/uart_cmd_decoder.sv
// UART command parser: 'w' addr data -> SDRAM write, 'r' addr -> SDRAM read, low read byte back to TX.
// Latency: cmd valid 1 cycle after last byte, tx valid 1 cycle after rd_valid; holds valid until ready, drops RX bytes while busy.
module uart_cmd_decoder #(
    parameter int AddrWidth     = 22,
    parameter int DataWidth     = 16,
    parameter int TimeoutCycles = 1_330_000
) (
    input  logic                 i_sys_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_valid,
    input  logic [7:0]           i_rx_data,
    output logic                 o_cmd_valid,
    input  logic                 i_cmd_ready,
    output logic                 o_cmd_write,
    output logic [AddrWidth-1:0] o_cmd_addr,
    output logic [DataWidth-1:0] o_cmd_wdata,
    input  logic                 i_rd_valid,
    input  logic [DataWidth-1:0] i_rd_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic [7:0]           o_tx_data,
    output logic                 o_overrun
);

    localparam int CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        ISSUE,
        WAIT_RD,
        SEND_TX
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_wr;
    logic [AddrWidth-1:0]   r_addr;
    logic [DataWidth-1:0]   r_wdata;
    logic [7:0]             r_tx_data;
    logic [CntW-1:0]        r_cnt;
    logic                   r_overrun;
    logic                   w_accept;
    logic                   w_timeout;
    logic                   w_overrun;
    logic                   w_rd_hi_unused;

    assign w_rd_hi_unused = ^i_rd_data[DataWidth-1:8];

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_rx_valid && (i_rx_data == 8'h77 || i_rx_data == 8'h72)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = GET_ADDR;
                end
            end
            GET_ADDR, GET_DATA: begin
                // Timeout wins: a byte landing on the abandon edge is dropped as overrun.
                if (r_cnt == CntMax) begin
                    w_timeout   = 1'b1;
                    w_overrun   = i_rx_valid;
                    w_state_nxt = IDLE;
                end else if (i_rx_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (r_state == GET_ADDR && r_wr) ? GET_DATA : ISSUE;
                end
            end
            ISSUE: begin
                w_overrun = i_rx_valid;
                if (i_cmd_ready) begin
                    w_state_nxt = r_wr ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                w_overrun = i_rx_valid;
                if (i_rd_valid) begin
                    w_state_nxt = SEND_TX;
                end
            end
            SEND_TX: begin
                w_overrun = i_rx_valid;
                if (i_tx_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_tx_data <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_overrun;
            if (w_accept) begin
                case (r_state)
                    IDLE: begin
                        r_wr    <= (i_rx_data == 8'h77);
                        r_wdata <= '0;
                    end
                    GET_ADDR: r_addr  <= {{(AddrWidth-8){1'b0}}, i_rx_data};
                    GET_DATA: r_wdata <= {{(DataWidth-8){1'b0}}, i_rx_data};
                    default:  ;
                endcase
            end
            if (r_state == WAIT_RD && i_rd_valid) begin
                r_tx_data <= i_rd_data[7:0];
            end
            if ((r_state == GET_ADDR || r_state == GET_DATA) && !w_accept && !w_timeout) begin
                r_cnt <= r_cnt + CntW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_cmd_valid = (r_state == ISSUE);
    assign o_cmd_write = r_wr && (r_state == ISSUE);
    assign o_cmd_addr  = r_addr;
    assign o_cmd_wdata = r_wdata;
    assign o_tx_valid  = (r_state == SEND_TX);
    assign o_tx_data   = r_tx_data;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with a queue-based scoreboard on the cmd and tx handshakes.
module tb_uart_cmd_decoder;

    localparam int AW = 22;
    localparam int DW = 16;
    localparam int TO = 16;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          cmd_valid;
    logic          cmd_ready = 1'b0;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [7:0]    tx_data;
    logic          overrun;

    cmd_t       cmd_q[$];
    logic [7:0] tx_q[$];
    int         checks = 0;
    int         errors = 0;
    int         ovr_seen = 0;
    int         ovr_exp = 0;

    uart_cmd_decoder #(.AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
        .i_sys_clk  (clk),
        .i_rst_n    (rst_n),
        .i_rx_valid (rx_valid),
        .i_rx_data  (rx_data),
        .o_cmd_valid(cmd_valid),
        .i_cmd_ready(cmd_ready),
        .o_cmd_write(cmd_write),
        .o_cmd_addr (cmd_addr),
        .o_cmd_wdata(cmd_wdata),
        .i_rd_valid (rd_valid),
        .i_rd_data  (rd_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_tx_data  (tx_data),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change #1 after posedge, so the negedge view is what the next posedge samples.
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_valid && cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {1'b1, cmd_write, cmd_addr, cmd_wdata}, 64'd0);
                end else begin
                    e = cmd_q.pop_front();
                    chk("cmd", {cmd_write, cmd_addr, cmd_wdata}, {e.wr, e.addr, e.wdata});
                end
            end
            if (rst_n && tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    chk("unexpected_tx", {1'b1, tx_data}, 64'd0);
                end else begin
                    chk("tx_byte", tx_data, tx_q.pop_front());
                end
            end
            if (overrun) ovr_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic rd_pulse(input logic [DW-1:0] d);
        rd_valid = 1'b1;
        rd_data  = d;
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic exp_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.wr = w; c.addr = a; c.wdata = d;
        cmd_q.push_back(c);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_write"}, cmd_write, 0);
        chk({tag, "_cmd_addr"},  cmd_addr, 0);
        chk({tag, "_cmd_wdata"}, cmd_wdata, 0);
        chk({tag, "_tx_valid"},  tx_valid, 0);
        chk({tag, "_tx_data"},   tx_data, 0);
        chk({tag, "_overrun"},   overrun, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        tx_ready  = 1'b1;

        // 1: write with ready tied high -> single-cycle valid
        exp_cmd(1'b1, 22'd5, 16'h000F);
        send(8'h77); send(8'h05); send(8'h0F);
        chk("t1_cmd_latency", cmd_valid, 1);
        tick();
        chk("t1_valid_drops", cmd_valid, 0);
        repeat (3) tick();
        chk("t1_no_tx", tx_valid, 0);

        // 2: read with delayed ready and delayed tx_ready
        cmd_ready = 1'b0;
        tx_ready  = 1'b0;
        exp_cmd(1'b0, 22'd5, 16'h0000);
        send(8'h72); send(8'h05);
        for (int i = 0; i < 3; i++) begin
            chk("t2_cmd_held", {cmd_valid, cmd_write, cmd_addr}, {1'b1, 1'b0, 22'd5});
            tick();
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("t2_valid_drops", cmd_valid, 0);
        tx_q.push_back(8'hAD);
        rd_pulse(16'hDEAD);
        chk("t2_tx_latency", {tx_valid, tx_data}, {1'b1, 8'hAD});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_tx_held", {tx_valid, tx_data}, {1'b1, 8'hAD});
        end
        tx_ready = 1'b1;
        tick();
        chk("t2_tx_drops", tx_valid, 0);
        cmd_ready = 1'b1;

        // 3: junk byte ignored in IDLE, stray rd_valid ignored
        rd_pulse(16'hFFFF);
        chk("t3_stray_rd", tx_valid, 0);
        exp_cmd(1'b0, 22'd7, 16'h0000);
        tx_q.push_back(8'h34);
        send(8'h41); send(8'h72); send(8'h07);
        tick();
        rd_pulse(16'h1234);
        tick();

        // 4: partial write abandoned by timeout
        send(8'h77); send(8'h05);
        repeat (TO + 4) tick();
        chk("t4_no_cmd", cmd_valid, 0);
        exp_cmd(1'b0, 22'd1, 16'h0000);
        tx_q.push_back(8'hEF);
        send(8'h72); send(8'h01);
        tick();
        rd_pulse(16'hBEEF);
        tick();

        // 5: overrun while waiting for read data
        exp_cmd(1'b0, 22'd3, 16'h0000);
        tx_q.push_back(8'h55);
        send(8'h72); send(8'h03);
        tick();
        ovr_exp++;
        send(8'h11);
        chk("t5_overrun_pulse", overrun, 1);
        tick();
        chk("t5_overrun_clear", overrun, 0);
        rd_pulse(16'h0055);
        tick();

        // 6: reset in ISSUE, then in SEND_TX, then normal traffic
        cmd_ready = 1'b0;
        send(8'h77); send(8'h09); send(8'h01);
        chk("t6_in_issue", cmd_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t6_rst_issue");
        tick();
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        tx_ready  = 1'b0;
        exp_cmd(1'b0, 22'd2, 16'h0000);
        send(8'h72); send(8'h02);
        tick();
        rd_pulse(16'h00AA);
        chk("t6_in_send", {tx_valid, tx_data}, {1'b1, 8'hAA});
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t6_rst_send");
        tick();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        exp_cmd(1'b1, 22'h0A, 16'h000B);
        send(8'h77); send(8'h0A); send(8'h0B);
        tick();
        exp_cmd(1'b0, 22'h0A, 16'h0000);
        tx_q.push_back(8'h99);
        send(8'h72); send(8'h0A);
        tick();
        rd_pulse(16'h0099);
        repeat (4) tick();

        chk("cmd_queue_drained", cmd_q.size(), 0);
        chk("tx_queue_drained", tx_q.size(), 0);
        chk("overrun_count", ovr_seen, ovr_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
